// File: rtl/debounce_sync_array.sv
// Multi-channel synchronizer and debouncer. Each channel has its own
// qualification FSM that produces a clean level, rise/fall pulses and optional rise auto-repeat.
module debounce_sync_array #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int ASSERT_CYCLES   = 16,
  parameter int DEASSERT_CYCLES = 10,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [CHANNELS-1:0] data_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                any_rise_o
);

  localparam int QUAL_MAX = (ASSERT_CYCLES > DEASSERT_CYCLES) ? ASSERT_CYCLES : DEASSERT_CYCLES;
  localparam int QW       = $clog2(QUAL_MAX + 1);
  localparam int RW       = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam int REP_LAST = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

  localparam logic [QW-1:0] A_TERM = QW'(ASSERT_CYCLES - 1);
  localparam logic [QW-1:0] D_TERM = QW'(DEASSERT_CYCLES - 1);
  localparam logic [RW-1:0] R_TERM = RW'(REP_LAST);
  localparam logic [QW-1:0] Q_ONE  = QW'(1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } state_t;

  logic [CHANNELS-1:0] rise_next;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [QW-1:0]          qual_q, qual_d;
    logic [RW-1:0]          rep_q, rep_d;
    logic                   rise_d, fall_d;
    logic                   level_q, rise_q, fall_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], data_i[c]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Counters clear on their terminal count, so they can never wrap.
    always_comb begin
      state_d = state_q;
      qual_d  = qual_q;
      rep_d   = rep_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        LOW: begin
          if (s) begin
            if (qual_q == A_TERM) begin
              state_d = HIGH;
              qual_d  = '0;
              rep_d   = '0;
              rise_d  = 1'b1;
            end else begin
              qual_d = qual_q + Q_ONE;
            end
          end else begin
            qual_d = '0;
          end
        end
        HIGH: begin
          if (!s) begin
            rep_d = '0;
            if (qual_q == D_TERM) begin
              state_d = LOW;
              qual_d  = '0;
              fall_d  = 1'b1;
            end else begin
              qual_d = qual_q + Q_ONE;
            end
          end else begin
            qual_d = '0;
            if (REPEAT_CYCLES > 0) begin
              if (rep_q == R_TERM) begin
                rise_d = 1'b1;
                rep_d  = '0;
              end else begin
                rep_d = rep_q + R_ONE;
              end
            end
          end
        end
        default: begin
          state_d = LOW;
          qual_d  = '0;
          rep_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        state_q <= LOW;
        qual_q  <= '0;
        rep_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        qual_q  <= qual_d;
        rep_q   <= rep_d;
        level_q <= (state_d == HIGH);
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign rise_next[c] = rise_d;
    assign level_o[c]   = level_q;
    assign rise_o[c]    = rise_q;
    assign fall_o[c]    = fall_q;
  end

  // Registered from the same next-state terms so it lines up with rise_o.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      any_rise_o <= 1'b0;
    end else begin
      any_rise_o <= |rise_next;
    end
  end

endmodule
